sw_max_tracker: RTL and testbench

SW_MAX_TRACKER -- requirements
Module: sw_max_tracker

---
 rtl/sw_max_tracker_pkg.sv | 26 ++
 rtl/sw_pos_counter.sv | 56 +++++
 rtl/sw_max_tracker.sv | 104 ++++++++++
 tb/tb_sw_max_tracker.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/sw_max_tracker_pkg.sv
// Shared score-width header plus FSM encodings and the max-compare helper for sw_max_tracker.
// The score width comes from the guarded `V_E_F_Bit define so every file agrees on it.
`ifndef SW_UTIL_V
`define SW_UTIL_V
`define V_E_F_Bit 16
`endif

package sw_max_tracker_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_TRACK = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    TRACK = ST_TRACK,
    DONE  = ST_DONE
  } state_t;

  // Strict signed compare: ties keep the earliest position.
  function automatic logic is_new_max(input logic signed [`V_E_F_Bit-1:0] v,
                                      input logic signed [`V_E_F_Bit-1:0] m);
    return v > m;
  endfunction

endpackage

// File: rtl/sw_pos_counter.sv
// Column/pass position counters for sw_max_tracker: column wrap with sticky overflow,
// saturating pass count. Presents the position of the cell being accepted this cycle.
module sw_pos_counter #(
  parameter int COL_W  = 10,
  parameter int PASS_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              accept,
  input  logic              new_line,
  output logic [COL_W-1:0]  cell_col,
  output logic [PASS_W-1:0] cell_pass,
  output logic              ovf
);

  logic [COL_W-1:0]  col_q;
  logic [PASS_W-1:0] pass_q;
  logic              first_q;
  logic              wrap;

  // The first accepted cell of an alignment is pass 0 even when it opens a line.
  always_comb begin
    cell_col  = col_q + COL_W'(1);
    cell_pass = pass_q;
    wrap      = 1'b0;
    if (new_line) begin
      cell_col = '0;
      if (!first_q && pass_q != {PASS_W{1'b1}})
        cell_pass = pass_q + PASS_W'(1);
    end else begin
      wrap = (col_q == {COL_W{1'b1}});
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_q   <= '0;
      pass_q  <= '0;
      first_q <= 1'b1;
      ovf     <= 1'b0;
    end else if (clear) begin
      col_q   <= '0;
      pass_q  <= '0;
      first_q <= 1'b1;
      ovf     <= 1'b0;
    end else if (accept) begin
      col_q   <= cell_col;
      pass_q  <= cell_pass;
      first_q <= 1'b0;
      if (wrap)
        ovf <= 1'b1;
    end
  end

endmodule

// File: rtl/sw_max_tracker.sv
// Tracks the running maximum score from the final PE across an alignment (IDLE/TRACK/DONE).
// Optional feature macro SW_MAX_TRACKER_POS_EN adds column/pass position tracking.
module sw_max_tracker
  import sw_max_tracker_pkg::*;
#(
  parameter int COL_W  = 10,
  parameter int PASS_W = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         valid_in,
  input  logic                         newLineIn,
  input  logic signed [`V_E_F_Bit-1:0] vIn,
  input  logic                         last_in,
  input  logic                         ack,
  output logic signed [`V_E_F_Bit-1:0] max_score,
  output logic [COL_W-1:0]             max_col,
  output logic [PASS_W-1:0]            max_pass,
  output logic                         busy,
  output logic                         done,
  output logic                         col_ovf
);

  state_t state;
  logic   accept;
  logic   update;

  assign accept = (state == TRACK) && valid_in && !start;
  assign update = accept && is_new_max(vIn, max_score);

  // start outranks everything, including ack and cells arriving in the same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      max_score <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else if (start) begin
      state     <= TRACK;
      max_score <= '0;
      busy      <= 1'b1;
      done      <= 1'b0;
    end else begin
      case (state)
        TRACK: begin
          if (valid_in) begin
            if (update)
              max_score <= vIn;
            if (last_in) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        DONE: begin
          if (ack) begin
            state <= IDLE;
            done  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SW_MAX_TRACKER_POS_EN
  logic [COL_W-1:0]  cell_col;
  logic [PASS_W-1:0] cell_pass;

  sw_pos_counter #(
    .COL_W (COL_W),
    .PASS_W(PASS_W)
  ) u_pos (
    .clk      (clk),
    .rst      (rst),
    .clear    (start),
    .accept   (accept),
    .new_line (newLineIn),
    .cell_col (cell_col),
    .cell_pass(cell_pass),
    .ovf      (col_ovf)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      max_col  <= '0;
      max_pass <= '0;
    end else if (start) begin
      max_col  <= '0;
      max_pass <= '0;
    end else if (update) begin
      max_col  <= cell_col;
      max_pass <= cell_pass;
    end
  end
`else
  assign max_col  = '0;
  assign max_pass = '0;
  assign col_ovf  = 1'b0;
`endif

endmodule

// File: tb/tb_sw_max_tracker.sv
// Directed bench for sw_max_tracker; expectations follow SW_MAX_TRACKER_POS_EN when defined.
`ifndef SW_UTIL_V
`define SW_UTIL_V
`define V_E_F_Bit 16
`endif

module tb_sw_max_tracker;

  localparam int W = `V_E_F_Bit;
`ifdef SW_MAX_TRACKER_POS_EN
  localparam bit POS = 1'b1;
`else
  localparam bit POS = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic                start = 1'b0;
  logic                valid_in = 1'b0;
  logic                new_line = 1'b0;
  logic signed [W-1:0] v_in = '0;
  logic                last_in = 1'b0;
  logic                ack = 1'b0;

  logic signed [W-1:0] max_score, max_score2;
  logic [9:0]          max_col;
  logic [1:0]          max_col2;
  logic [7:0]          max_pass, max_pass2;
  logic                busy, done, col_ovf, busy2, done2, col_ovf2;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  sw_max_tracker dut (
    .clk(clk), .rst(rst), .start(start), .valid_in(valid_in), .newLineIn(new_line),
    .vIn(v_in), .last_in(last_in), .ack(ack), .max_score(max_score), .max_col(max_col),
    .max_pass(max_pass), .busy(busy), .done(done), .col_ovf(col_ovf)
  );

  sw_max_tracker #(.COL_W(2), .PASS_W(8)) dut2 (
    .clk(clk), .rst(rst), .start(start), .valid_in(valid_in), .newLineIn(new_line),
    .vIn(v_in), .last_in(last_in), .ack(ack), .max_score(max_score2), .max_col(max_col2),
    .max_pass(max_pass2), .busy(busy2), .done(done2), .col_ovf(col_ovf2)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // One cell per call; returns at the negedge after the capturing posedge.
  task automatic applyStimulus(input bit nl, input int v, input bit last);
    valid_in = 1'b1;
    new_line = nl;
    v_in     = v[W-1:0];
    last_in  = last;
    @(negedge clk);
    valid_in = 1'b0;
    new_line = 1'b0;
    last_in  = 1'b0;
  endtask

  task automatic pulseStart(input bit with_ack);
    start = 1'b1;
    ack   = with_ack;
    @(negedge clk);
    start = 1'b0;
    ack   = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    checkOutput("rst_max", 32'(max_score), 0);
    checkOutput("rst_busy", 32'(busy), 0);
    checkOutput("rst_done", 32'(done), 0);
    rst = 1'b1;
    @(negedge clk);

    // Single pass: peak in the middle column
    pulseStart(1'b0);
    checkOutput("t1_busy", 32'(busy), 1);
    applyStimulus(1'b1, 3, 1'b0);
    checkOutput("t1_max_a", 32'(max_score), 3);
    applyStimulus(1'b0, 7, 1'b0);
    checkOutput("t1_done_early", 32'(done), 0);
    applyStimulus(1'b0, 5, 1'b1);
    checkOutput("t1_done", 32'(done), 1);
    checkOutput("t1_busy_off", 32'(busy), 0);
    checkOutput("t1_max", 32'(max_score), 7);
    checkOutput("t1_col", 32'(max_col), POS ? 1 : 0);
    checkOutput("t1_pass", 32'(max_pass), 0);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    checkOutput("t1_ack_done", 32'(done), 0);
    applyStimulus(1'b1, 100, 1'b0);
    checkOutput("t1_idle_hold", 32'(max_score), 7);

    // Two passes with a tie in pass 0
    pulseStart(1'b0);
    checkOutput("t2_cleared", 32'(max_score), 0);
    applyStimulus(1'b1, 4, 1'b0);
    applyStimulus(1'b0, 4, 1'b0);
    checkOutput("t2_tie_max", 32'(max_score), 4);
    checkOutput("t2_tie_col", 32'(max_col), 0);
    checkOutput("t2_tie_pass", 32'(max_pass), 0);
    applyStimulus(1'b1, 2, 1'b0);
    applyStimulus(1'b0, 9, 1'b1);
    checkOutput("t2_max", 32'(max_score), 9);
    checkOutput("t2_col", 32'(max_col), POS ? 1 : 0);
    checkOutput("t2_pass", 32'(max_pass), POS ? 1 : 0);
    checkOutput("t2_done", 32'(done), 1);

    // start and ack together in DONE: start wins
    pulseStart(1'b1);
    checkOutput("t3_busy", 32'(busy), 1);
    checkOutput("t3_done", 32'(done), 0);
    checkOutput("t3_max", 32'(max_score), 0);

    // Column wrap on the narrow instance
    applyStimulus(1'b1, 1, 1'b0);
    applyStimulus(1'b0, 2, 1'b0);
    applyStimulus(1'b0, 3, 1'b0);
    applyStimulus(1'b0, 4, 1'b0);
    checkOutput("t4_ovf_before", 32'(col_ovf2), 0);
    applyStimulus(1'b0, 5, 1'b1);
    checkOutput("t4_ovf", 32'(col_ovf2), POS ? 1 : 0);
    checkOutput("t4_col2", 32'(max_col2), 0);
    checkOutput("t4_max2", 32'(max_score2), 5);
    checkOutput("t4_col_wide", 32'(max_col), POS ? 4 : 0);
    checkOutput("t4_ovf_wide", 32'(col_ovf), 0);

    // Negative score never updates; start clears overflow
    pulseStart(1'b0);
    checkOutput("t5_ovf_clr", 32'(col_ovf2), 0);
    applyStimulus(1'b1, -3, 1'b0);
    checkOutput("t5_neg_max", 32'(max_score), 0);
    applyStimulus(1'b0, 6, 1'b0);
    checkOutput("t5_max", 32'(max_score), 6);

    // Reset mid-TRACK discards the alignment
    rst = 1'b0;
    #1;
    checkOutput("t6_max", 32'(max_score), 0);
    checkOutput("t6_busy", 32'(busy), 0);
    checkOutput("t6_done", 32'(done), 0);
    checkOutput("t6_col", 32'(max_col), 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    applyStimulus(1'b1, 50, 1'b1);
    checkOutput("t6_ignored_max", 32'(max_score), 0);
    checkOutput("t6_ignored_done", 32'(done), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
